// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line, sampler hand-off and received-frame outputs of the UART receive controller
interface uart_rx_ctrl_if #(parameter int DATA_W = 8);
  logic              RX_IN;
  logic [7:0]        prescale;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              sampled_bit;
  logic [4:0]        edge_cnt;
  logic              dat_samp_en;
  logic [DATA_W-1:0] P_DATA;
  logic              data_valid;
  logic              par_err;
  logic              stp_err;
  logic              busy;
  modport master (
    output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
    input  edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
  );
  modport slave (
    input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
    output edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start detect, edge counting, deserialise, parity/stop check)
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  uart_rx_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam int BW = $clog2(DATA_W + 1);
  logic [2:0]        state;
  logic [4:0]        edge_q;
  logic [7:0]        pre_l;
  logic              par_en_l;
  logic              par_typ_l;
  logic              par_fail;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] p_data;
  logic              dv;
  logic              pe;
  logic              se;
  logic              wrap;
  logic              cap;
  assign wrap = {3'd0, edge_q} == pre_l - 8'd1;
  assign cap  = {3'd0, edge_q} == (pre_l >> 1) + 8'd1;
  assign bus.edge_cnt    = edge_q;
  assign bus.dat_samp_en = state != IDLE;
  assign bus.busy        = state != IDLE;
  assign bus.P_DATA      = p_data;
  assign bus.data_valid  = dv;
  assign bus.par_err     = pe;
  assign bus.stp_err     = se;
  // Frame FSM: the evaluation happens on the stop-bit capture edge so the strobe and the return to IDLE share one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      edge_q    <= 5'd0;
      pre_l     <= 8'd0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      par_fail  <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      p_data    <= '0;
      dv        <= 1'b0;
      pe        <= 1'b0;
      se        <= 1'b0;
    end else begin
      dv <= 1'b0;
      pe <= 1'b0;
      se <= 1'b0;
      if (state != IDLE) edge_q <= wrap ? 5'd0 : edge_q + 5'd1;
      case (state)
        IDLE: begin
          edge_q   <= 5'd0;
          par_fail <= 1'b0;
          if (!bus.RX_IN) begin
            state     <= START;
            edge_q    <= 5'd1;
            pre_l     <= bus.prescale;
            par_en_l  <= bus.PAR_EN;
            par_typ_l <= bus.PAR_TYP;
          end
        end
        START: begin
          if (cap && bus.sampled_bit) begin
            state  <= IDLE;
            edge_q <= 5'd0;
          end else if (wrap) state <= DATA;
        end
        DATA: begin
          if (cap) begin
            shift   <= {bus.sampled_bit, shift[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          if (wrap && bit_cnt == BW'(DATA_W)) begin
            state   <= par_en_l ? PARITY : STOP;
            bit_cnt <= '0;
          end
        end
        PARITY: begin
          if (cap) par_fail <= bus.sampled_bit != (^shift ^ par_typ_l);
          if (wrap) state <= STOP;
        end
        STOP: begin
          if (cap) begin
            state  <= IDLE;
            edge_q <= 5'd0;
            if (!par_fail && bus.sampled_bit) begin
              p_data <= shift;
              dv     <= 1'b1;
            end else begin
              pe <= par_fail;
              se <= !bus.sampled_bit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
